// File: rtl/vga_timing_pkg.sv
// Shared types for the VGA timing delay line.
// Field widths and the per-stage timing bundle.
package vga_timing_pkg;

  localparam int HC_W  = 11;
  localparam int VC_W  = 10;
  localparam int POS_W = 12;

  typedef struct packed {
    logic [HC_W-1:0] hcount;
    logic [VC_W-1:0] vcount;
    logic            hsync;
    logic            vsync;
    logic            hblnk;
    logic            vblnk;
  } vga_timing_t;

  typedef struct packed {
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
  } vga_pos_t;

  function automatic int fill_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/vga_delay_stage.sv
// One timing pipeline stage: a reset-to-zero vga_timing_t register.
// Ports: clk, rst (sync, active-high), d (stage input), q (stage output).
module vga_delay_stage
  import vga_timing_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  vga_timing_t d,
  output vga_timing_t q
);

  vga_timing_t q_q;
  vga_timing_t q_d;

  always_comb begin
    q_d = d;
    if (rst) begin
      q_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/vga_timing_delay_line.sv
// Delays VGA timing by DEPTH clocks; adds primed and frame_tick.
// Ports: clk, rst (sync, active-high), hcount/vcount/hsync/vsync/
//   hblnk/vblnk/xpos/ypos _in -> _out, primed, frame_tick.
// Macro VGA_DELAY_POS_FRAME_LATCH_EN: latch xpos/ypos once per frame
//   on frame_tick instead of delaying them through the pipeline.
module vga_timing_delay_line #(
  parameter int DEPTH = 3,
  parameter int HC_W  = 11,
  parameter int VC_W  = 10,
  parameter int POS_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [HC_W-1:0]  hcount_in,
  input  logic [VC_W-1:0]  vcount_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             hblnk_in,
  input  logic             vblnk_in,
  input  logic [POS_W-1:0] xpos_in,
  input  logic [POS_W-1:0] ypos_in,
  output logic [HC_W-1:0]  hcount_out,
  output logic [VC_W-1:0]  vcount_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             hblnk_out,
  output logic             vblnk_out,
  output logic [POS_W-1:0] xpos_out,
  output logic [POS_W-1:0] ypos_out,
  output logic             primed,
  output logic             frame_tick
);

  import vga_timing_pkg::*;

  localparam int CNT_W = fill_w(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  vga_timing_t in_s;
  vga_timing_t out_s;
  vga_timing_t stage_q [DEPTH];

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             primed_q;
  logic             primed_d;
  logic             tick_q;
  logic             tick_d;
  logic             v_next;

  always_comb begin
    in_s        = '0;
    in_s.hcount = hcount_in;
    in_s.vcount = vcount_in;
    in_s.hsync  = hsync_in;
    in_s.vsync  = vsync_in;
    in_s.hblnk  = hblnk_in;
    in_s.vblnk  = vblnk_in;
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_first
      vga_delay_stage u_stage (
        .clk (clk),
        .rst (rst),
        .d   (in_s),
        .q   (stage_q[k])
      );
    end else begin : g_rest
      vga_delay_stage u_stage (
        .clk (clk),
        .rst (rst),
        .d   (stage_q[k-1]),
        .q   (stage_q[k])
      );
    end
  end

  assign out_s = stage_q[DEPTH-1];

  // vblnk about to be loaded into the output stage
  if (DEPTH == 1) begin : g_vnext_in
    assign v_next = vblnk_in;
  end else begin : g_vnext_stage
    assign v_next = stage_q[DEPTH-2].vblnk;
  end

  // Fill counter saturates at DEPTH; primed follows it and sticks.
  always_comb begin
    cnt_d    = cnt_q;
    primed_d = primed_q;
    if (rst) begin
      cnt_d    = '0;
      primed_d = 1'b0;
    end else begin
      if (cnt_q != FULL) begin
        cnt_d = cnt_q + 1'b1;
      end
      primed_d = primed_q | (cnt_d == FULL);
    end
  end

  // Rising edge of vblnk_out, gated by the next primed value.
  always_comb begin
    tick_d = 1'b0;
    if (!rst) begin
      tick_d = v_next & ~out_s.vblnk & primed_d;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q    <= cnt_d;
    primed_q <= primed_d;
    tick_q   <= tick_d;
  end

  assign hcount_out = out_s.hcount;
  assign vcount_out = out_s.vcount;
  assign hsync_out  = out_s.hsync;
  assign vsync_out  = out_s.vsync;
  assign hblnk_out  = out_s.hblnk;
  assign vblnk_out  = out_s.vblnk;
  assign primed     = primed_q;
  assign frame_tick = tick_q;

`ifdef VGA_DELAY_POS_FRAME_LATCH_EN

  // Positions tracked continuously in reset so a valid value
  // exists before the first frame; held for the whole frame after.
  vga_pos_t pos_q;
  vga_pos_t pos_d;

  always_comb begin
    pos_d = pos_q;
    if (rst || tick_d) begin
      pos_d.x = xpos_in;
      pos_d.y = ypos_in;
    end
  end

  always_ff @(posedge clk) begin
    pos_q <= pos_d;
  end

  assign xpos_out = pos_q.x;
  assign ypos_out = pos_q.y;

`else

  vga_pos_t pos_q [DEPTH];
  vga_pos_t pos_d [DEPTH];

  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      pos_d[k] = '0;
      if (!rst) begin
        if (k == 0) begin
          pos_d[k].x = xpos_in;
          pos_d[k].y = ypos_in;
        end else begin
          pos_d[k] = pos_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++) begin
      pos_q[k] <= pos_d[k];
    end
  end

  assign xpos_out = pos_q[DEPTH-1].x;
  assign ypos_out = pos_q[DEPTH-1].y;

`endif

endmodule

// File: tb/tb_vga_timing_delay_line.sv
// Bench for vga_timing_delay_line at DEPTH=3 and DEPTH=1.
// Directed table, reset, random and frame/position sequences.
module tb_vga_timing_delay_line;

  localparam int D3 = 3;
  localparam int D1 = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [10:0] hc_in;
  logic [9:0]  vc_in;
  logic        hs_in, vs_in, hb_in, vb_in;
  logic [11:0] x_in, y_in;

  logic [10:0] hc3, hc1;
  logic [9:0]  vc3, vc1;
  logic        hs3, vs3, hb3, vb3, hs1, vs1, hb1, vb1;
  logic [11:0] x3, y3, x1, y1;
  logic        pr3, pr1, tk3, tk1;

  vga_timing_delay_line #(.DEPTH(D3)) u3 (
    .clk(clk), .rst(rst),
    .hcount_in(hc_in), .vcount_in(vc_in),
    .hsync_in(hs_in), .vsync_in(vs_in),
    .hblnk_in(hb_in), .vblnk_in(vb_in),
    .xpos_in(x_in), .ypos_in(y_in),
    .hcount_out(hc3), .vcount_out(vc3),
    .hsync_out(hs3), .vsync_out(vs3),
    .hblnk_out(hb3), .vblnk_out(vb3),
    .xpos_out(x3), .ypos_out(y3),
    .primed(pr3), .frame_tick(tk3)
  );

  vga_timing_delay_line #(.DEPTH(D1)) u1 (
    .clk(clk), .rst(rst),
    .hcount_in(hc_in), .vcount_in(vc_in),
    .hsync_in(hs_in), .vsync_in(vs_in),
    .hblnk_in(hb_in), .vblnk_in(vb_in),
    .xpos_in(x_in), .ypos_in(y_in),
    .hcount_out(hc1), .vcount_out(vc1),
    .hsync_out(hs1), .vsync_out(vs1),
    .hblnk_out(hb1), .vblnk_out(vb1),
    .xpos_out(x1), .ypos_out(y1),
    .primed(pr1), .frame_tick(tk1)
  );

  typedef struct packed {
    logic [10:0] hc;
    logic [9:0]  vc;
    logic        hs, vs, hb, vb;
    logic [11:0] x, y;
  } smp_t;

  typedef struct packed {
    smp_t s;
    logic primed;
    logic tick;
  } obs_t;

  typedef struct {
    logic [10:0] hc;
    logic [10:0] exp_hc;
    logic        exp_primed;
  } vec_t;

  smp_t        hist [16];
  int          e = 0;
  obs_t        exp3 = '0;
  obs_t        exp1 = '0;
  logic [23:0] lat3 = '0;
  logic [23:0] lat1 = '0;
  int          n_chk = 0;
  int          n_fail = 0;

  function automatic obs_t model(input int d, input obs_t prev);
    obs_t r;
    r = '0;
    if (e >= d) begin
      r.s      = hist[(e - d + 1) & 15];
      r.primed = 1'b1;
      r.tick   = r.s.vb & ~prev.s.vb;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req,
               $time);
    end
  endtask

  // Apply current inputs for one edge, advance model, compare all.
  task automatic step();
    smp_t cur;
    obs_t a3, a1;
    cur = {hc_in, vc_in, hs_in, vs_in, hb_in, vb_in, x_in, y_in};
    @(posedge clk);
    if (rst) begin
      e = 0;
    end else begin
      e++;
      hist[e & 15] = cur;
    end
    exp3 = model(D3, exp3);
    exp1 = model(D1, exp1);
`ifdef VGA_DELAY_POS_FRAME_LATCH_EN
    if (rst || exp3.tick) lat3 = {cur.x, cur.y};
    if (rst || exp1.tick) lat1 = {cur.x, cur.y};
    exp3.s.x = lat3[23:12];
    exp3.s.y = lat3[11:0];
    exp1.s.x = lat1[23:12];
    exp1.s.y = lat1[11:0];
`endif
    #1;
    a3 = {hc3, vc3, hs3, vs3, hb3, vb3, x3, y3, pr3, tk3};
    a1 = {hc1, vc1, hs1, vs1, hb1, vb1, x1, y1, pr1, tk1};
    check("dut_d3", 64'(a3), 64'(exp3));
    check("dut_d1", 64'(a1), 64'(exp1));
  endtask

  vec_t tbl [8];
  int   ticks;
  int   lat_d3, lat_d1, since;
  logic hit_tick;

  initial begin
    tbl[0] = '{11'd0, 11'd0, 1'b0};
    tbl[1] = '{11'd1, 11'd0, 1'b0};
    tbl[2] = '{11'd2, 11'd0, 1'b1};
    tbl[3] = '{11'd3, 11'd1, 1'b1};
    tbl[4] = '{11'd4, 11'd2, 1'b1};
    tbl[5] = '{11'd5, 11'd3, 1'b1};
    tbl[6] = '{11'd6, 11'd4, 1'b1};
    tbl[7] = '{11'd7, 11'd5, 1'b1};

    rst = 1'b1;
    hc_in = '0; vc_in = '0;
    hs_in = 0; vs_in = 0; hb_in = 0; vb_in = 0;
    x_in = 12'd7; y_in = 12'd9;
    step();
    step();
    check("reset_primed", 64'(pr3), 64'd0);
    check("reset_hcount", 64'(hc3), 64'd0);

    // hcount ramp from reset release
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      hc_in = tbl[i].hc;
      step();
      check($sformatf("ramp_hc[%0d]", i), 64'(hc3), 64'(tbl[i].exp_hc));
      check($sformatf("ramp_pr[%0d]", i), 64'(pr3),
            64'(tbl[i].exp_primed));
    end
    for (int h = 8; h < 400; h++) begin
      hc_in = 11'(h);
      vc_in = 10'(h / 7);
      hs_in = (h % 13) == 0;
      step();
    end

    // one-cycle reset mid-line
    hc_in = 11'd400;
    rst = 1'b1;
    step();
    check("midrst_hc", 64'(hc3), 64'd0);
    check("midrst_pr", 64'({pr3, pr1}), 64'd0);
    rst = 1'b0;
    hc_in = 11'd401; step();
    check("refill1_hc", 64'({hc3, pr3}), 64'd0);
    check("refill1_d1", 64'({hc1, pr1}), 64'({11'd401, 1'b1}));
    hc_in = 11'd402; step();
    check("refill2_hc", 64'({hc3, pr3}), 64'd0);
    hc_in = 11'd403; step();
    check("refill3_hc", 64'({hc3, pr3}), 64'({11'd401, 1'b1}));

    // random timing stimulus
    for (int i = 0; i < 300; i++) begin
      hc_in = 11'($urandom);
      vc_in = 10'($urandom);
      {hs_in, vs_in, hb_in, vb_in} = 4'($urandom);
      x_in = 12'($urandom);
      y_in = 12'($urandom);
      step();
    end

    // quiet lead-in, then 3 frames with a mid-frame position change
    {hs_in, vs_in, hb_in, vb_in} = 4'd0;
    x_in = 12'd100;
    y_in = 12'd50;
    for (int i = 0; i < 6; i++) step();
    ticks = 0;
    lat_d3 = -1;
    lat_d1 = -1;
    since = -1;
    hit_tick = 1'b0;
    for (int f = 0; f < 3; f++) begin
      for (int j = 0; j < 645; j++) begin
        vb_in = (j >= 600);
        hb_in = (j >= 600);
        hc_in = 11'(j);
        vc_in = 10'(f);
        if (f == 1 && j == 300) begin
          x_in = 12'd200;
          since = 0;
        end
        step();
        if (tk3) ticks++;
        if (since >= 0) begin
          since++;
          if (x3 == 12'd200 && lat_d3 < 0) begin
            lat_d3 = since;
            hit_tick = tk3;
          end
          if (x1 == 12'd200 && lat_d1 < 0) lat_d1 = since;
        end
      end
    end
    vb_in = 1'b0;
    hb_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (tk3) ticks++;
    end
    check("tick_count", 64'(ticks), 64'd3);
`ifdef VGA_DELAY_POS_FRAME_LATCH_EN
    check("pos_at_tick", 64'(hit_tick), 64'd1);
    check("pos_latched", 64'(lat_d3 > 0), 64'd1);
`else
    check("pos_lat_d3", 64'(lat_d3), 64'(D3));
    check("pos_lat_d1", 64'(lat_d1), 64'(D1));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_delay_line.md
Name: vga_timing_delay_line

Overview:
- Parametrised VGA timing alignment pipeline, placed between the timing generator and the draw/overlay stages.
- Delays hcount, vcount, hsync, vsync, hblnk and vblnk by exactly DEPTH clocks, so timing matches the latency of downstream pixel logic.
- Adds a pipeline-primed flag, a start-of-frame pulse, and controlled handling of the mouse/object position inputs.

Parameters:
- DEPTH, 3, number of pipeline stages (timing latency in clocks); legal range 1..16.
- HC_W, 11, hcount width.
- VC_W, 10, vcount width.
- POS_W, 12, xpos/ypos width.

Ports:
- clk  in  1  pixel clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- hcount_in  in  HC_W  horizontal counter.
- vcount_in  in  VC_W  vertical counter.
- hsync_in  in  1  horizontal sync.
- vsync_in  in  1  vertical sync.
- hblnk_in  in  1  horizontal blank.
- vblnk_in  in  1  vertical blank.
- xpos_in  in  POS_W  object/mouse X position.
- ypos_in  in  POS_W  object/mouse Y position.
- hcount_out  out  HC_W  hcount_in delayed DEPTH clocks.
- vcount_out  out  VC_W  vcount_in delayed DEPTH clocks.
- hsync_out  out  1  hsync_in delayed DEPTH clocks.
- vsync_out  out  1  vsync_in delayed DEPTH clocks.
- hblnk_out  out  1  hblnk_in delayed DEPTH clocks.
- vblnk_out  out  1  vblnk_in delayed DEPTH clocks.
- xpos_out  out  POS_W  X position; timing depends on the optional feature.
- ypos_out  out  POS_W  Y position; timing depends on the optional feature.
- primed  out  1  high once the output holds post-reset data.
- frame_tick  out  1  one-cycle pulse on the first cycle of vblnk_out high.

Behaviour:
- Pipeline
  - DEPTH register stages, each holding {hcount, vcount, hsync, vsync, hblnk, vblnk}.
  - Stage 0 loads the inputs; stage k loads stage k-1; the outputs are driven directly from stage DEPTH-1.
  - No combinational path from any input to any output.
- Reset (rst=1 at a clock edge)
  - Every stage and every timing output is cleared to 0.
  - primed=0, frame_tick=0, fill counter=0.
  - Reset mid-frame discards all in-flight samples; no partial flush.
- Latency
  - A sample present at the inputs at edge n appears at the outputs after edge n+DEPTH-1, i.e. it is visible during cycle n+DEPTH-1..n+DEPTH.
  - Equivalently, out(t) = in(t-DEPTH) in clock cycles.
- Fill counter and primed
  - The fill counter is $clog2(DEPTH+1) bits wide, increments every non-reset edge and saturates at DEPTH.
  - primed is registered high on the edge at which the counter reaches DEPTH, which is the same edge at which the first post-reset sample reaches the outputs.
  - primed then stays high until the next rst.
- frame_tick
  - Registered. At each edge: frame_tick <= v_next & ~vblnk_out & p_next.
    - v_next is the vblnk value being loaded into the output stage.
    - p_next is the next value of primed.
  - The result is high exactly in the first cycle vblnk_out=1.
  - Never asserted before primed, so the 0->1 transition coming out of reset does not tick.
  - A vblnk_in high for a single cycle still produces one tick.
- Width rules: no arithmetic; all fields pass through unmodified, with no truncation or extension.

Optional Feature:
- Macro: VGA_DELAY_POS_FRAME_LATCH_EN.
- Defined:
  - xpos_out/ypos_out are loaded from xpos_in/ypos_in only on the edge that sets frame_tick, and hold otherwise.
  - Positions are therefore constant for an entire frame (no tearing).
  - During rst, xpos_out/ypos_out load xpos_in/ypos_in every edge, so a valid position is present before the first frame.
- Undefined:
  - xpos/ypos are carried through the same DEPTH-stage pipeline as the timing fields, with latency DEPTH.
  - Reset value is 0.

Decomposition:
- Package vga_timing_pkg holds:
  - constants HC_W=11, VC_W=10, POS_W=12;
  - a packed struct vga_timing_t {hcount, vcount, hsync, vsync, hblnk, vblnk}, so each stage is one vga_timing_t register.
- One natural sub-module, vga_delay_stage: a single reset-to-zero register of vga_timing_t, instantiated DEPTH times with a generate loop.
- Fill counter, frame_tick and position logic stay in the top module.

Test Plan:
- DEPTH=3: drive hcount_in=0..799 incrementing from reset release -> hcount_out=0 until after the 3rd edge, then equals hcount_in from 3 cycles earlier; primed rises on edge 3.
- DEPTH=1 and DEPTH=8: random timing stimulus -> every output field equals its input delayed exactly DEPTH cycles; primed rises on edge DEPTH.
- vblnk_in low 600 cycles then high 45 cycles, repeated 3 frames -> frame_tick is exactly one cycle wide, coincides with the first vblnk_out=1 cycle, 3 pulses total, none at reset release.
- Assert rst for 1 cycle mid-line (hcount=400) -> all outputs and primed are 0 the next cycle; the refill takes DEPTH cycles again and no stale sample emerges.
- With VGA_DELAY_POS_FRAME_LATCH_EN: change xpos_in 100->200 mid-frame -> xpos_out stays 100 until the frame_tick cycle, then reads 200.
- Without the macro: the same stimulus -> xpos_out changes to 200 exactly DEPTH cycles after the input change.
